// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Drains a show-ahead fifo and emits exactly LEN+1 beats per command on a
//   registered valid/ready/last stream. The reader stalls while the fifo is
//   empty or while the sink applies backpressure. BUSY stays high for the
//   whole command, and DONE pulses once when the sink accepts the final beat.
//
// Parameters
//   width     data width (must match the attached fifo)
//   widthlen  width of LEN; a burst is 1 .. 2**widthlen beats
//
// Ports
//   CLK, RST               clock and synchronous active-high reset
//   START, LEN             command strobe and beat count minus one
//   BUSY, DONE             command in progress / one-cycle completion pulse
//   FIFO_Q, FIFO_EMPTY     fifo head word and empty flag
//   FIFO_RD                pop strobe (combinational)
//   OUT_DATA/VALID/LAST    registered stream outputs
//   OUT_READY              sink ready
module fifo_burst_reader #(
  parameter int width    = 32,
  parameter int widthlen = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [widthlen-1:0] LEN,
  output logic                BUSY,
  output logic                DONE,
  input  logic [width-1:0]    FIFO_Q,
  input  logic                FIFO_EMPTY,
  output logic                FIFO_RD,
  output logic [width-1:0]    OUT_DATA,
  output logic                OUT_VALID,
  output logic                OUT_LAST,
  input  logic                OUT_READY
);

  // One extra bit so that LEN = 2**widthlen-1 gives REM = 2**widthlen without wrapping.
  localparam int RW = widthlen + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             load;
  logic             xfer;

  // The output slot can take a new word when it is empty, or when it is
  // draining during this same cycle.
  assign xfer = valid_q && OUT_READY;
  assign load = (state_q == ST_RUN) && !FIFO_EMPTY && (rem_q != '0) &&
                (!valid_q || OUT_READY);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          rem_d   = RW'(LEN) + RW'(1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load) begin
          data_d  = FIFO_Q;
          valid_d = 1'b1;
          rem_d   = rem_q - RW'(1);
          last_d  = (rem_q == RW'(1));
          // Final word is in the output register; only its hand-off remains.
          if (rem_q == RW'(1)) begin
            state_d = ST_FLUSH;
          end
        end else if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign FIFO_RD   = load;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign OUT_DATA  = data_q;
  assign OUT_VALID = valid_q;
  assign OUT_LAST  = last_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Self-checking bench for fifo_burst_reader. A queue stands in for the
//   show-ahead fifo. A command-level model tracks the expected stream:
//   pops so far, beats accepted, the word held on the output, BUSY, and DONE.
//   Scenario tasks drive randomized ready and write patterns and compare
//   against that model on every falling edge.
module tb_fifo_burst_reader;

  localparam int W  = 32;
  localparam int WL = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [WL-1:0] LEN;
  logic          BUSY;
  logic          DONE;
  logic [W-1:0]  FIFO_Q;
  logic          FIFO_EMPTY;
  logic          FIFO_RD;
  logic [W-1:0]  OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_LAST;
  logic          OUT_READY;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] fq[$];

  always #5 CLK = ~CLK;

  fifo_burst_reader #(.width(W), .widthlen(WL)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .BUSY(BUSY), .DONE(DONE),
    .FIFO_Q(FIFO_Q), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD(FIFO_RD),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST),
    .OUT_READY(OUT_READY)
  );

  // Show-ahead fifo view. The head word is random garbage while the fifo is empty.
  task automatic drive_fifo();
    FIFO_EMPTY = (fq.size() == 0);
    FIFO_Q     = (fq.size() == 0) ? W'($urandom) : fq[0];
  endtask

  // One command from START to DONE.
  // rmode: 0 = ready always high, 1 = 1010.., 2 = random.
  // wr_period: push one word every wr_period cycles (0 = none).
  task automatic run_burst(input string name, input int len, input int rmode,
                           input int wr_period, input bit noise);
    int pops = 0, beats = 0, cyc = 0, dut_pops = 0, dut_beats = 0;
    int bound = 8 * (len + 1) + 40;
    bit exp_valid = 0, exp_busy = 0, exp_done = 0, finished = 0;
    bit exp_rd, xfer, last_xfer;
    logic [W-1:0] exp_held = '0;
    while (!finished) begin
      START = (cyc == 0);
      LEN   = WL'(len);
      if (cyc != 0 && noise && exp_busy) begin
        START = 1'($urandom_range(0, 1));
        LEN   = WL'($urandom);
      end
      case (rmode)
        0:       OUT_READY = 1'b1;
        1:       OUT_READY = (cyc % 2 == 0);
        default: OUT_READY = 1'($urandom_range(0, 1));
      endcase
      drive_fifo();
      @(negedge CLK);
      exp_rd = exp_busy && (pops < len + 1) && (fq.size() > 0) &&
               (!exp_valid || OUT_READY);
      xfer   = exp_valid && OUT_READY;
      if (FIFO_RD) dut_pops++;
      if (OUT_VALID && OUT_READY) dut_beats++;
      total++;
      if (FIFO_RD !== exp_rd)
        begin bad++; $display("FAIL %s fifo_rd cyc=%0d got=%0b exp=%0b", name, cyc, FIFO_RD, exp_rd); end
      total++;
      if (OUT_VALID !== exp_valid)
        begin bad++; $display("FAIL %s out_valid cyc=%0d got=%0b exp=%0b", name, cyc, OUT_VALID, exp_valid); end
      total++;
      if (BUSY !== exp_busy)
        begin bad++; $display("FAIL %s busy cyc=%0d got=%0b exp=%0b", name, cyc, BUSY, exp_busy); end
      total++;
      if (DONE !== exp_done)
        begin bad++; $display("FAIL %s done cyc=%0d got=%0b exp=%0b", name, cyc, DONE, exp_done); end
      if (exp_valid) begin
        total++;
        if (OUT_DATA !== exp_held)
          begin bad++; $display("FAIL %s out_data cyc=%0d got=%h exp=%h", name, cyc, OUT_DATA, exp_held); end
        total++;
        if (OUT_LAST !== (pops == len + 1))
          begin bad++; $display("FAIL %s out_last cyc=%0d got=%0b exp=%0b", name, cyc, OUT_LAST, pops == len + 1); end
      end
      if (exp_done) finished = 1;
      @(posedge CLK);
      #1;
      last_xfer = xfer && (beats == len);
      if (xfer) beats++;
      if (exp_rd) begin
        exp_held  = fq.pop_front();
        pops++;
        exp_valid = 1;
      end else if (xfer) begin
        exp_valid = 0;
      end
      if (wr_period > 0 && (cyc % wr_period) == wr_period - 1) fq.push_back(W'($urandom));
      exp_done = last_xfer;
      if (last_xfer) exp_busy = 0;
      if (cyc == 0) exp_busy = 1;
      cyc++;
      if (cyc > bound && !finished) begin
        total++; bad++;
        $display("FAIL %s timeout cyc=%0d beats=%0d exp=%0d", name, cyc, beats, len + 1);
        finished = 1;
      end
    end
    START = 1'b0;
    total++;
    if (dut_pops != len + 1)
      begin bad++; $display("FAIL %s pop_count got=%0d exp=%0d", name, dut_pops, len + 1); end
    total++;
    if (dut_beats != len + 1)
      begin bad++; $display("FAIL %s beat_count got=%0d exp=%0d", name, dut_beats, len + 1); end
    $display("burst %s len=%0d pops=%0d beats=%0d cycles=%0d", name, len, dut_pops, dut_beats, cyc);
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; LEN = '0; OUT_READY = 1'b1;
    fq.delete();
    fq.push_back(32'h1234_5678);
    drive_fifo();
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%0b exp=0", OUT_VALID); end
    total++; if (OUT_LAST  !== 1'b0) begin bad++; $display("FAIL reset out_last got=%0b exp=0", OUT_LAST); end
    total++; if (OUT_DATA  !== '0)   begin bad++; $display("FAIL reset out_data got=%h exp=0", OUT_DATA); end
    total++; if (BUSY      !== 1'b0) begin bad++; $display("FAIL reset busy got=%0b exp=0", BUSY); end
    total++; if (DONE      !== 1'b0) begin bad++; $display("FAIL reset done got=%0b exp=0", DONE); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    total++; if (FIFO_RD !== 1'b0) begin bad++; $display("FAIL idle fifo_rd got=%0b exp=0", FIFO_RD); end
    total++; if (BUSY    !== 1'b0) begin bad++; $display("FAIL idle busy got=%0b exp=0", BUSY); end
    @(posedge CLK);
    #1;
    fq.delete();
    $display("reset checks done");
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) fq.push_back(W'(i));
    run_burst("t1_len3", 3, 0, 0, 0);
    fq.delete();
    fq.push_back(32'h0000_00A5);
    run_burst("t2_len0", 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    fq.delete();
    for (int i = 0; i < 16; i++) fq.push_back(W'($urandom));
    run_burst("t3_toggle", 7, 1, 0, 0);
  endtask

  task automatic test_empty_fifo();
    fq.delete();
    run_burst("t4_trickle", 4, 0, 3, 0);
  endtask

  task automatic test_max_len();
    fq.delete();
    for (int i = 0; i < 4; i++) fq.push_back(W'($urandom));
    run_burst("t5_len255", 255, 2, 1, 1);
  endtask

  task automatic test_reset_mid_burst();
    fq.delete();
    for (int i = 0; i < 8; i++) fq.push_back(W'($urandom));
    OUT_READY = 1'b0;
    START = 1'b1; LEN = WL'(5);
    drive_fifo();
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL t6 held_valid got=%0b exp=1", OUT_VALID); end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL t6 out_valid got=%0b exp=0", OUT_VALID); end
    total++; if (BUSY      !== 1'b0) begin bad++; $display("FAIL t6 busy got=%0b exp=0", BUSY); end
    total++; if (OUT_LAST  !== 1'b0) begin bad++; $display("FAIL t6 out_last got=%0b exp=0", OUT_LAST); end
    @(posedge CLK);
    #1;
    fq.delete();
    for (int i = 0; i < 6; i++) fq.push_back(W'($urandom));
    run_burst("t6_after_reset", 5, 2, 0, 0);
  endtask

  task automatic test_back_to_back();
    fq.delete();
    for (int i = 0; i < 20; i++) fq.push_back(W'($urandom));
    run_burst("b2b_a", 2, 2, 0, 0);
    run_burst("b2b_b", 5, 2, 0, 0);
    run_burst("b2b_c", 0, 2, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int len = $urandom_range(0, 20);
      int pre = $urandom_range(0, 5);
      int wp  = $urandom_range(1, 3);
      for (int i = 0; i < pre; i++) fq.push_back(W'($urandom));
      run_burst($sformatf("rand%0d", n), len, 2, wp, 1);
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; LEN = '0; OUT_READY = 1'b0;
    FIFO_EMPTY = 1'b1; FIFO_Q = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_fifo();
    test_max_len();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
